// File: rtl/sba_arbiter_if.sv
// SBA arbiter bus bundle: two master request ports, the shared slave port and status outputs.
// The slave modport is the arbiter's view; the master modport is the view of whatever drives it.
interface sba_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] i_m0_addr;
  logic              i_m0_stb;
  logic [BE_W-1:0]   i_m0_we;
  logic [DATA_W-1:0] i_m0_dat_w;
  logic              o_m0_ack;

  logic [ADDR_W-1:0] i_m1_addr;
  logic              i_m1_stb;
  logic [BE_W-1:0]   i_m1_we;
  logic [DATA_W-1:0] i_m1_dat_w;
  logic              o_m1_ack;

  logic [DATA_W-1:0] o_dat_r;

  logic [ADDR_W-1:0] o_s_addr;
  logic              o_s_stb;
  logic [BE_W-1:0]   o_s_we;
  logic [DATA_W-1:0] o_s_dat_w;
  logic              i_s_ack;
  logic [DATA_W-1:0] i_s_dat_r;

  logic [1:0]        o_grant;
  logic              o_timeout;

  modport slave (
    input  i_m0_addr, i_m0_stb, i_m0_we, i_m0_dat_w,
    input  i_m1_addr, i_m1_stb, i_m1_we, i_m1_dat_w,
    input  i_s_ack, i_s_dat_r,
    output o_m0_ack, o_m1_ack, o_dat_r,
    output o_s_addr, o_s_stb, o_s_we, o_s_dat_w,
    output o_grant, o_timeout
  );

  modport master (
    output i_m0_addr, i_m0_stb, i_m0_we, i_m0_dat_w,
    output i_m1_addr, i_m1_stb, i_m1_we, i_m1_dat_w,
    output i_s_ack, i_s_dat_r,
    input  o_m0_ack, o_m1_ack, o_dat_r,
    input  o_s_addr, o_s_stb, o_s_we, o_s_dat_w,
    input  o_grant, o_timeout
  );
endinterface

// File: rtl/sba_arbiter.sv
// Two-master round-robin arbiter for the SBA slave bus, one transaction per grant, with a
// one-cycle idle gap between grants and a watchdog that terminates transactions nobody acks.
module sba_arbiter #(
  parameter int unsigned         ADDR_W   = 32,
  parameter int unsigned         DATA_W   = 32,
  parameter int unsigned         TIMEOUT  = 255,
  parameter logic [DATA_W-1:0]   ERR_DATA = 32'hDEAD_BEEF
) (
  input logic         i_clk,
  input logic         i_rst_n,
  sba_arbiter_if.slave bus
);
  localparam int unsigned BE_W = DATA_W / 8;
  localparam logic [15:0] WdogLimit = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StGrant0, StGrant1, StRecover} state_e;

  state_e      state_q, state_d, arb_state;
  logic        last_q, last_d;
  logic [15:0] wdog_q, wdog_d;
  logic        timeout_q, timeout_d;
  logic [1:0]  grant_q;

  logic              sel_m1;
  logic              cur_stb;
  logic              ack;
  logic [ADDR_W-1:0] s_addr;
  logic              s_stb;
  logic [BE_W-1:0]   s_we;
  logic [DATA_W-1:0] s_dat_w;
  logic [DATA_W-1:0] dat_r;

  // On contention the master that did not own the last grant wins.
  always_comb begin
    unique case ({bus.i_m1_stb, bus.i_m0_stb})
      2'b01:   arb_state = StGrant0;
      2'b10:   arb_state = StGrant1;
      2'b11:   arb_state = last_q ? StGrant0 : StGrant1;
      default: arb_state = StIdle;
    endcase
  end

  assign sel_m1  = (state_q == StGrant1);
  assign cur_stb = sel_m1 ? bus.i_m1_stb : bus.i_m0_stb;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    wdog_d    = wdog_q;
    timeout_d = 1'b0;
    ack       = 1'b0;
    s_addr    = '0;
    s_stb     = 1'b0;
    s_we      = '0;
    s_dat_w   = '0;
    dat_r     = '0;
    unique case (state_q)
      StIdle, StRecover: begin
        state_d = arb_state;
        wdog_d  = '0;
      end
      StGrant0, StGrant1: begin
        s_addr  = sel_m1 ? bus.i_m1_addr  : bus.i_m0_addr;
        s_we    = sel_m1 ? bus.i_m1_we    : bus.i_m0_we;
        s_dat_w = sel_m1 ? bus.i_m1_dat_w : bus.i_m0_dat_w;
        s_stb   = cur_stb;
        dat_r   = bus.i_s_dat_r;
        if (bus.i_s_ack) begin
          ack     = 1'b1;
          state_d = StRecover;
          last_d  = sel_m1;
          wdog_d  = '0;
        end else if (!cur_stb) begin
          // Master gave up: release the bus without an ack.
          state_d = StRecover;
          last_d  = sel_m1;
          wdog_d  = '0;
        end else if (wdog_q == WdogLimit) begin
          ack       = 1'b1;
          dat_r     = ERR_DATA;
          timeout_d = 1'b1;
          state_d   = StRecover;
          last_d    = sel_m1;
          wdog_d    = '0;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      last_q    <= 1'b1;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
      grant_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
      grant_q   <= {state_d == StGrant1, state_d == StGrant0};
    end
  end

  assign bus.o_s_addr  = s_addr;
  assign bus.o_s_stb   = s_stb;
  assign bus.o_s_we    = s_we;
  assign bus.o_s_dat_w = s_dat_w;
  assign bus.o_dat_r   = dat_r;
  assign bus.o_m0_ack  = ack & ~sel_m1;
  assign bus.o_m1_ack  = ack & sel_m1;
  assign bus.o_grant   = grant_q;
  assign bus.o_timeout = timeout_q;
endmodule

// File: tb/tb_sba_arbiter.sv
// Bench for sba_arbiter: directed scenarios plus randomized contention against a
// transaction-timeline reference model, with a registered SBA slave model.
module tb_sba_arbiter;
  localparam int unsigned TIMEOUT = 8;
  localparam logic [31:0] ERR     = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sba_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  sba_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TIMEOUT),
    .ERR_DATA(ERR)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  // Slave behaviour: addresses 0x5xxx_xxxx are unmapped; latency is addr[2:0]+1 cycles.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return a ^ 32'hA5A5_0F0F;
  endfunction
  function automatic int lat(input logic [31:0] a);
    return int'(a[2:0]) + 1;
  endfunction
  function automatic bit mapped(input logic [31:0] a);
    return a[31:28] != 4'h5;
  endfunction
  function automatic bit will_time_out(input logic [31:0] a);
    return !(mapped(a) && (lat(a) + 1 <= int'(TIMEOUT)));
  endfunction
  function automatic int grant_len(input logic [31:0] a);
    return will_time_out(a) ? int'(TIMEOUT) : lat(a) + 1;
  endfunction

  logic        s_ack_q = 1'b0;
  logic        s_extra_q = 1'b0;
  logic [31:0] s_dat_q = '0;
  int          s_cnt_q = 0;
  bit          stale_mode = 1'b0;

  always @(posedge clk) begin
    s_dat_q <= mem_rd(bus.o_s_addr);
    if (stale_mode && s_ack_q && !s_extra_q) begin
      s_ack_q   <= 1'b1;
      s_extra_q <= 1'b1;
    end else begin
      s_ack_q   <= bus.o_s_stb && !s_ack_q && mapped(bus.o_s_addr) &&
                   (s_cnt_q == lat(bus.o_s_addr) - 1);
      s_extra_q <= 1'b0;
    end
    s_cnt_q <= (bus.o_s_stb && !s_ack_q) ? s_cnt_q + 1 : 0;
  end

  assign bus.i_s_ack   = s_ack_q;
  assign bus.i_s_dat_r = s_dat_q;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stale_mode = 1'b0;
    bus.i_m0_addr = '0; bus.i_m0_stb = 1'b0; bus.i_m0_we = '0; bus.i_m0_dat_w = '0;
    bus.i_m1_addr = '0; bus.i_m1_stb = 1'b0; bus.i_m1_we = '0; bus.i_m1_dat_w = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({bus.o_grant, bus.o_s_stb, bus.o_m0_ack, bus.o_m1_ack, bus.o_timeout} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got grant=%b stb=%b ack0=%b ack1=%b to=%b want all 0",
               bus.o_grant, bus.o_s_stb, bus.o_m0_ack, bus.o_m1_ack, bus.o_timeout);
    end
    checks++;
    if (bus.o_s_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_addr got %h want 0", bus.o_s_addr);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    bus.i_m0_addr = 32'h0000_0010;
    bus.i_m0_stb  = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.o_grant !== 2'b00) begin
      errors++; $display("FAIL single_idle_grant got %b want 00", bus.o_grant);
    end
    step(); @(negedge clk);
    checks++;
    if (bus.o_grant !== 2'b01 || bus.o_s_stb !== 1'b1 || bus.o_s_addr !== 32'h10) begin
      errors++;
      $display("FAIL single_grant got grant=%b stb=%b addr=%h want 01 1 00000010",
               bus.o_grant, bus.o_s_stb, bus.o_s_addr);
    end
    step(); @(negedge clk);
    checks++;
    if (bus.o_m0_ack !== 1'b1 || bus.o_m1_ack !== 1'b0 || bus.o_dat_r !== mem_rd(32'h10)) begin
      errors++;
      $display("FAIL single_ack got ack0=%b ack1=%b dat=%h want 1 0 %h",
               bus.o_m0_ack, bus.o_m1_ack, bus.o_dat_r, mem_rd(32'h10));
    end
    step();
    bus.i_m0_stb = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.o_s_stb !== 1'b0 || bus.o_grant !== 2'b00 || bus.o_m0_ack !== 1'b0) begin
      errors++;
      $display("FAIL single_recover got stb=%b grant=%b ack0=%b want 0 00 0",
               bus.o_s_stb, bus.o_grant, bus.o_m0_ack);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.i_m0_addr = 32'h0000_0100;
    bus.i_m1_addr = 32'h0000_0200;
    bus.i_m0_stb  = 1'b1;
    bus.i_m1_stb  = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      int p;
      int own;
      logic [1:0] eg;
      step(); @(negedge clk);
      p   = (k - 1) % 3;
      own = ((k - 1) / 3) % 2;
      eg  = (p == 2) ? 2'b00 : (own == 1 ? 2'b10 : 2'b01);
      checks++;
      if (bus.o_grant !== eg || bus.o_s_stb !== (p != 2)) begin
        errors++;
        $display("FAIL rr_cycle%0d got grant=%b stb=%b want %b %b",
                 k, bus.o_grant, bus.o_s_stb, eg, p != 2);
      end
      if (p == 1) begin
        checks++;
        if ({bus.o_m1_ack, bus.o_m0_ack} !== eg) begin
          errors++;
          $display("FAIL rr_ack%0d got %b want %b", k, {bus.o_m1_ack, bus.o_m0_ack}, eg);
        end
      end
    end
    bus.i_m0_stb = 1'b0;
    bus.i_m1_stb = 1'b0;
    step();
  endtask

  task automatic test_stale_ack();
    do_reset();
    stale_mode    = 1'b1;
    bus.i_m0_addr = 32'h0000_0300;
    bus.i_m1_addr = 32'h0000_0408;
    bus.i_m0_stb  = 1'b1;
    bus.i_m1_stb  = 1'b1;
    step(); step(); @(negedge clk);
    checks++;
    if (bus.o_m0_ack !== 1'b1) begin
      errors++; $display("FAIL stale_m0_ack got %b want 1", bus.o_m0_ack);
    end
    step();
    bus.i_m0_stb = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.o_m0_ack !== 1'b0 || bus.o_m1_ack !== 1'b0 || bus.o_s_stb !== 1'b0) begin
      errors++;
      $display("FAIL stale_recover got ack0=%b ack1=%b stb=%b want 0 0 0",
               bus.o_m0_ack, bus.o_m1_ack, bus.o_s_stb);
    end
    step(); @(negedge clk);
    checks++;
    if (bus.o_grant !== 2'b10 || bus.o_m1_ack !== 1'b0) begin
      errors++;
      $display("FAIL stale_m1_early got grant=%b ack1=%b want 10 0", bus.o_grant, bus.o_m1_ack);
    end
    step(); @(negedge clk);
    checks++;
    if (bus.o_m1_ack !== 1'b1 || bus.o_dat_r !== mem_rd(32'h408)) begin
      errors++;
      $display("FAIL stale_m1_ack got ack1=%b dat=%h want 1 %h",
               bus.o_m1_ack, bus.o_dat_r, mem_rd(32'h408));
    end
    step();
    bus.i_m1_stb = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    do_reset();
    bus.i_m1_addr = 32'h5000_0000;
    bus.i_m1_stb  = 1'b1;
    for (int g = 1; g <= int'(TIMEOUT); g++) begin
      step(); @(negedge clk);
      checks++;
      if (g < int'(TIMEOUT)) begin
        if (bus.o_grant !== 2'b10 || bus.o_m1_ack !== 1'b0 || bus.o_timeout !== 1'b0) begin
          errors++;
          $display("FAIL to_wait%0d got grant=%b ack1=%b to=%b want 10 0 0",
                   g, bus.o_grant, bus.o_m1_ack, bus.o_timeout);
        end
      end else if (bus.o_m1_ack !== 1'b1 || bus.o_m0_ack !== 1'b0 || bus.o_dat_r !== ERR) begin
        errors++;
        $display("FAIL to_ack got ack1=%b ack0=%b dat=%h want 1 0 %h",
                 bus.o_m1_ack, bus.o_m0_ack, bus.o_dat_r, ERR);
      end
    end
    step();
    bus.i_m1_stb = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.o_timeout !== 1'b1 || bus.o_grant !== 2'b00 || bus.o_s_stb !== 1'b0) begin
      errors++;
      $display("FAIL to_pulse got to=%b grant=%b stb=%b want 1 00 0",
               bus.o_timeout, bus.o_grant, bus.o_s_stb);
    end
    step(); @(negedge clk);
    checks++;
    if (bus.o_timeout !== 1'b0) begin
      errors++; $display("FAIL to_pulse_end got %b want 0", bus.o_timeout);
    end
  endtask

  task automatic test_ack_on_limit();
    do_reset();
    bus.i_m0_addr = 32'h0000_0106;
    bus.i_m0_stb  = 1'b1;
    for (int g = 1; g <= int'(TIMEOUT); g++) begin
      step(); @(negedge clk);
      checks++;
      if (g < int'(TIMEOUT)) begin
        if (bus.o_m0_ack !== 1'b0) begin
          errors++; $display("FAIL limit_wait%0d got ack0=%b want 0", g, bus.o_m0_ack);
        end
      end else if (bus.o_m0_ack !== 1'b1 || bus.o_dat_r !== mem_rd(32'h106)) begin
        errors++;
        $display("FAIL limit_ack got ack0=%b dat=%h want 1 %h",
                 bus.o_m0_ack, bus.o_dat_r, mem_rd(32'h106));
      end
    end
    step();
    bus.i_m0_stb = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.o_timeout !== 1'b0 || bus.o_grant !== 2'b00) begin
      errors++;
      $display("FAIL limit_no_to got to=%b grant=%b want 0 00", bus.o_timeout, bus.o_grant);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.i_m0_addr  = 32'h0000_0020;
    bus.i_m0_we    = 4'b0010;
    bus.i_m0_dat_w = 32'h0000_AB00;
    bus.i_m0_stb   = 1'b1;
    step(); @(negedge clk);
    checks++;
    if (bus.o_grant !== 2'b01 || bus.o_s_we !== 4'b0010 || bus.o_s_dat_w !== 32'h0000_AB00) begin
      errors++;
      $display("FAIL rmid_write got grant=%b we=%b dat=%h want 01 0010 0000ab00",
               bus.o_grant, bus.o_s_we, bus.o_s_dat_w);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.o_s_stb, bus.o_grant, bus.o_m0_ack, bus.o_m1_ack} !== 5'b0 ||
        bus.o_s_we !== 4'b0) begin
      errors++;
      $display("FAIL rmid_async got stb=%b grant=%b ack0=%b ack1=%b we=%b want all 0",
               bus.o_s_stb, bus.o_grant, bus.o_m0_ack, bus.o_m1_ack, bus.o_s_we);
    end
    bus.i_m1_addr = 32'h0000_0040;
    bus.i_m1_stb  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(); @(negedge clk);
    checks++;
    if (bus.o_grant !== 2'b01) begin
      errors++; $display("FAIL rmid_first got grant=%b want 01", bus.o_grant);
    end
    bus.i_m0_stb = 1'b0;
    bus.i_m1_stb = 1'b0;
  endtask

  logic [31:0] ma [2];
  logic [3:0]  mw [2];
  logic [31:0] md [2];

  task automatic new_txn(input int m);
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 4) == 0) a[31:28] = 4'h5;
    else if (a[31:28] == 4'h5) a[31:28] = 4'h0;
    ma[m] = a;
    mw[m] = 4'($urandom);
    md[m] = $urandom;
    if (m == 0) begin
      bus.i_m0_addr = ma[0]; bus.i_m0_we = mw[0]; bus.i_m0_dat_w = md[0];
    end else begin
      bus.i_m1_addr = ma[1]; bus.i_m1_we = mw[1]; bus.i_m1_dat_w = md[1];
    end
  endtask

  // Both masters always busy: grants alternate, each lasting grant_len cycles plus one gap.
  task automatic test_random();
    int  n_txn = 40;
    int  done = 0;
    bit  in_grant = 1'b0;
    int  owner = 0;
    int  nxt_owner = 0;
    int  remain = 0;
    bit  to_pend = 1'b0;
    do_reset();
    new_txn(0);
    new_txn(1);
    bus.i_m0_stb = 1'b1;
    bus.i_m1_stb = 1'b1;
    for (int cyc = 0; cyc < 2000 && done < n_txn; cyc++) begin
      @(negedge clk);
      if (in_grant) begin
        logic [1:0]  eg;
        logic [31:0] ed;
        eg = (owner == 1) ? 2'b10 : 2'b01;
        checks++;
        if (bus.o_grant !== eg || bus.o_s_stb !== 1'b1 || bus.o_timeout !== 1'b0 ||
            bus.o_s_addr !== ma[owner] || bus.o_s_we !== mw[owner] ||
            bus.o_s_dat_w !== md[owner]) begin
          errors++;
          $display("FAIL rnd_grant cyc=%0d got grant=%b stb=%b to=%b addr=%h we=%b dat=%h want %b 1 0 %h %b %h",
                   cyc, bus.o_grant, bus.o_s_stb, bus.o_timeout, bus.o_s_addr, bus.o_s_we,
                   bus.o_s_dat_w, eg, ma[owner], mw[owner], md[owner]);
        end
        ed = will_time_out(ma[owner]) ? ERR : mem_rd(ma[owner]);
        checks++;
        if (remain == 1) begin
          if ({bus.o_m1_ack, bus.o_m0_ack} !== eg || bus.o_dat_r !== ed) begin
            errors++;
            $display("FAIL rnd_ack cyc=%0d got acks=%b dat=%h want %b %h",
                     cyc, {bus.o_m1_ack, bus.o_m0_ack}, bus.o_dat_r, eg, ed);
          end
        end else if ({bus.o_m1_ack, bus.o_m0_ack} !== 2'b00) begin
          errors++;
          $display("FAIL rnd_early_ack cyc=%0d got acks=%b want 00",
                   cyc, {bus.o_m1_ack, bus.o_m0_ack});
        end
      end else begin
        checks++;
        if (bus.o_grant !== 2'b00 || bus.o_s_stb !== 1'b0 ||
            {bus.o_m1_ack, bus.o_m0_ack} !== 2'b00 || bus.o_timeout !== to_pend) begin
          errors++;
          $display("FAIL rnd_gap cyc=%0d got grant=%b stb=%b acks=%b to=%b want 00 0 00 %b",
                   cyc, bus.o_grant, bus.o_s_stb, {bus.o_m1_ack, bus.o_m0_ack},
                   bus.o_timeout, to_pend);
        end
      end
      step();
      if (in_grant) begin
        if (remain == 1) begin
          to_pend   = will_time_out(ma[owner]);
          in_grant  = 1'b0;
          nxt_owner = 1 - owner;
          done++;
          new_txn(owner);
        end else begin
          remain--;
        end
      end else begin
        to_pend  = 1'b0;
        in_grant = 1'b1;
        owner    = nxt_owner;
        remain   = grant_len(ma[owner]);
      end
    end
    bus.i_m0_stb = 1'b0;
    bus.i_m1_stb = 1'b0;
    checks++;
    if (done !== n_txn) begin
      errors++; $display("FAIL rnd_progress got %0d transactions want %0d", done, n_txn);
    end
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_stale_ack();
    test_timeout();
    test_ack_on_limit();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
